// File: rtl/eeprom_pkg.sv
// Shared EEPROM bus definitions: device code, address width and FSM encodings.
package eeprom_pkg;

  localparam logic [3:0] DEV_CODE_DEF = 4'b1010;
  localparam int         ADDR_W_DEF   = 11;

  // One-hot protocol states, shared by master and slave models
  typedef enum logic [8:0] {
    S_IDLE      = 9'b0_0000_0001,
    S_CTRL      = 9'b0_0000_0010,
    S_CTRL_ACK  = 9'b0_0000_0100,
    S_ADDR      = 9'b0_0000_1000,
    S_ADDR_ACK  = 9'b0_0001_0000,
    S_WDATA     = 9'b0_0010_0000,
    S_WDATA_ACK = 9'b0_0100_0000,
    S_RDATA     = 9'b0_1000_0000,
    S_RDATA_ACK = 9'b1_0000_0000
  } state_e;

endpackage

// File: rtl/eeprom_slv_sync_edge.sv
// Two-flop synchronizers for SCL/SDA plus edge and START/STOP detection.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  // shift new samples into the chains
  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  // chains reset to the idle-bus level so no edge is seen leaving reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/eeprom_slv.sv
// Serial EEPROM slave: control/address/data byte protocol over an open-drain bus.
module eeprom_slv
  import eeprom_pkg::*;
#(
  parameter logic [3:0] DEV_CODE = DEV_CODE_DEF,
  parameter int         ADDR_W   = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              BUSY,
  output logic              WR_PULSE,
  output logic [ADDR_W-1:0] WR_ADDR
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge u_sync (
    .clk       (CLK),
    .rst_n     (RESET),
    .scl_in    (SCL),
    .sda_in    (SDA),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              sda_low_q, sda_low_d;
  logic              busy_q, busy_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              mem_we;
  logic [7:0]        mem_q [0:(2**ADDR_W)-1];
  logic [7:0]        in_byte, rd_byte;

  assign in_byte = {shreg_q[6:0], sda_s};
  assign rd_byte = mem_q[ptr_q];

  // Protocol FSM. In ACK states sda_low_q doubles as the phase bit: the first
  // SCL fall starts the ACK, the second ends it. START/STOP override everything.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    sda_low_d  = sda_low_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    mem_we     = 1'b0;
    if (stop_det || start_det) begin
      state_d   = stop_det ? S_IDLE : S_CTRL;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_CTRL: if (scl_rise) begin
          shreg_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (in_byte[7:4] == DEV_CODE) begin
              state_d              = S_CTRL_ACK;
              ptr_d[ADDR_W-1:8]    = (ADDR_W-8)'(in_byte[3:1]);
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_CTRL_ACK: if (scl_fall) begin
          if (!sda_low_q) begin
            sda_low_d = 1'b1;
            busy_d    = 1'b1;
          end else if (shreg_q[0]) begin
            // read: first data bit goes out on the same fall that ends the ACK
            state_d   = S_RDATA;
            shreg_d   = rd_byte << 1;
            sda_low_d = ~rd_byte[7];
          end else begin
            state_d   = S_ADDR;
            sda_low_d = 1'b0;
          end
        end
        S_ADDR: if (scl_rise) begin
          shreg_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d[7:0] = in_byte;
            state_d    = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (!sda_low_q) begin
            sda_low_d = 1'b1;
          end else begin
            sda_low_d = 1'b0;
            state_d   = S_WDATA;
          end
        end
        S_WDATA: if (scl_rise) begin
          shreg_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            mem_we     = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = ptr_q;
            ptr_d      = ptr_q + ADDR_W'(1);
            state_d    = S_WDATA_ACK;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = S_RDATA_ACK;
            end
          end else if (scl_fall) begin
            sda_low_d = ~shreg_q[7];
            shreg_d   = shreg_q << 1;
          end
        end
        S_RDATA_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s) begin
              state_d = S_RDATA;
              shreg_d = rd_byte;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ptr_q      <= '0;
      sda_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      sda_low_q  <= sda_low_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  // byte storage, deliberately not reset
  always_ff @(posedge CLK) begin
    if (RESET && mem_we) mem_q[ptr_q] <= in_byte;
  end

  assign SDA      = sda_low_q ? 1'b0 : 1'bz;
  assign BUSY     = busy_q;
  assign WR_PULSE = wr_pulse_q;
  assign WR_ADDR  = wr_addr_q;

endmodule

// File: tb/tb_eeprom_slv.sv
// Bench for eeprom_slv: bus-level master, table-driven write/readback plus corner sequences.
module tb_eeprom_slv;

  localparam int Q = 50;   // quarter SCL period; SCL period = 20 CLK

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  logic        busy, wr_pulse;
  logic [10:0] wr_addr;
  wire         sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  eeprom_slv #(.DEV_CODE(4'b1010), .ADDR_W(11)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .SCL      (scl),
    .SDA      (sda),
    .BUSY     (busy),
    .WR_PULSE (wr_pulse),
    .WR_ADDR  (wr_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [10:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // write-pulse scoreboard: every pulse must match the oldest expected address
  always @(negedge clk) begin
    if (wr_pulse) begin
      wr_cnt++;
      if (wr_exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL wr_unexpected act=%h exp=none", wr_addr);
      end else begin
        chk("wr_addr", {21'd0, wr_addr}, {21'd0, wr_exp_q.pop_front()});
      end
    end
  end

  task automatic bit_xfer(input logic b, output logic r);
    #Q m_low = ~b;
    #Q scl = 1'b1;
    #Q r = sda;
    #Q scl = 1'b0;
  endtask

  task automatic start_c();
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic stop_c();
    #Q m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  task automatic write_tx(input logic [10:0] a, input logic [7:0] d);
    logic ack;
    start_c();
    send_byte({4'hA, a[10:8], 1'b0}, ack);
    chk("wr_ctrl_ack", {31'd0, ack}, 0);
    chk("busy_after_ack", {31'd0, busy}, 1);
    send_byte(a[7:0], ack);
    chk("wr_addr_ack", {31'd0, ack}, 0);
    wr_exp_q.push_back(a);
    send_byte(d, ack);
    chk("wr_data_ack", {31'd0, ack}, 0);
    stop_c();
    chk("busy_after_stop", {31'd0, busy}, 0);
  endtask

  // random read of rd_exp_q.size() bytes starting at a; last byte is NACKed
  task automatic read_tx(input logic [10:0] a);
    logic ack;
    logic [7:0] d;
    int n;
    n = rd_exp_q.size();
    start_c();
    send_byte({4'hA, a[10:8], 1'b0}, ack);
    chk("rd_ctrl_ack", {31'd0, ack}, 0);
    send_byte(a[7:0], ack);
    chk("rd_addr_ack", {31'd0, ack}, 0);
    start_c();
    send_byte({4'hA, a[10:8], 1'b1}, ack);
    chk("rd_ctrlr_ack", {31'd0, ack}, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      chk("rd_data", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    end
    stop_c();
    chk("rd_busy_after_stop", {31'd0, busy}, 0);
  endtask

  initial begin
    logic ack, r;
    logic [7:0] d;
    int wr_before;

    vecs[0] = '{11'h134, 8'h5A, 8'h5A};
    vecs[1] = '{11'h2F0, 8'h00, 8'h00};
    vecs[2] = '{11'h7A5, 8'hC3, 8'hC3};
    vecs[3] = '{11'h0FF, 8'h81, 8'h81};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_sda", {31'd0, sda}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr_pulse", {31'd0, wr_pulse}, 0);
    chk("rst_wr_addr", {21'd0, wr_addr}, 0);
    rst_n = 1'b1;

    // table: write each byte, then read it back through a repeated start
    for (int i = 0; i < 4; i++) begin
      write_tx(vecs[i].addr, vecs[i].wdata);
      rd_exp_q.push_back(vecs[i].exp_rd);
      read_tx(vecs[i].addr);
    end

    // wrap: two bytes across the top of the address space
    start_c();
    send_byte(8'hAE, ack);
    chk("wrap_ctrl_ack", {31'd0, ack}, 0);
    send_byte(8'hFF, ack);
    chk("wrap_addr_ack", {31'd0, ack}, 0);
    wr_exp_q.push_back(11'h7FF);
    send_byte(8'h11, ack);
    chk("wrap_d0_ack", {31'd0, ack}, 0);
    wr_exp_q.push_back(11'h000);
    send_byte(8'h22, ack);
    chk("wrap_d1_ack", {31'd0, ack}, 0);
    stop_c();
    rd_exp_q.push_back(8'h11);
    rd_exp_q.push_back(8'h22);
    read_tx(11'h7FF);

    // wrong device code: no ACK, bus ignored until the next START
    start_c();
    send_byte(8'hB0, ack);
    chk("nodev_nack", {31'd0, ack}, 1);
    chk("nodev_busy", {31'd0, busy}, 0);
    send_byte(8'hA2, ack);
    chk("nodev_ignored", {31'd0, ack}, 1);
    chk("nodev_busy2", {31'd0, busy}, 0);
    stop_c();

    // abort: STOP after 4 data bits must not write
    wr_before = wr_cnt;
    start_c();
    send_byte(8'hA2, ack);
    chk("abort_ctrl_ack", {31'd0, ack}, 0);
    send_byte(8'h34, ack);
    chk("abort_addr_ack", {31'd0, ack}, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    stop_c();
    chk("abort_no_wr", wr_cnt, wr_before);
    rd_exp_q.push_back(8'h5A);
    read_tx(11'h134);

    // reset during read bit 3 of a zero byte: SDA released after one CLK
    start_c();
    send_byte(8'hA4, ack);
    chk("rstrd_ctrl_ack", {31'd0, ack}, 0);
    send_byte(8'hF0, ack);
    chk("rstrd_addr_ack", {31'd0, ack}, 0);
    start_c();
    send_byte(8'hA5, ack);
    chk("rstrd_ctrlr_ack", {31'd0, ack}, 0);
    for (int i = 0; i < 4; i++) begin
      bit_xfer(1'b1, r);
      chk("rstrd_bit", {31'd0, r}, 0);
    end
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q;
    chk("rstrd_driving", {31'd0, sda}, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstrd_sda_rel", {31'd0, sda}, 1);
    chk("rstrd_busy", {31'd0, busy}, 0);
    #20 rst_n = 1'b1;
    #Q scl = 1'b0;
    stop_c();

    // current-address read after reset starts at pointer 0
    start_c();
    send_byte(8'hA1, ack);
    chk("cur_ctrl_ack", {31'd0, ack}, 0);
    rd_exp_q.push_back(8'h22);
    recv_byte(1'b1, d);
    chk("cur_rd_ptr0", {24'd0, d}, {24'd0, rd_exp_q.pop_front()});
    stop_c();

    repeat (10) @(posedge clk);
    chk("wr_pending", wr_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
